sr_fetch: RTL and testbench

Instruction-fetch stage that sits directly upstream of the decode stage. It owns the program counter and issues in-order requests to instruction memory through a request/grant/response handshake. Returned words are held in a small prefetch FIFO. Each cycle it presents one instruction, its PC and PC+4 to decode, or a bubble (NOP) together with the decode freeze strobe.

---
 rtl/sr_fetch_pkg.sv | 25 ++
 rtl/sr_fetch_fifo.sv | 71 +++++++
 rtl/sr_fetch.sv | 124 ++++++++++++
 tb/tb_sr_fetch.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sr_fetch_pkg
// Description : Shared constants, types and helpers for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package sr_fetch_pkg;

   // Canonical RISC-V NOP (addi x0, x0, 0) shown to decode on a bubble
   localparam logic [31:0] c_RV_NOP           = 32'h0000_0013;
   localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_0000;

   // One prefetch buffer entry: the instruction word and the PC it came from
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Force a byte address onto a word boundary
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & ~32'h3;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sr_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sr_fetch_fifo
// Description : Small synchronous prefetch FIFO of {pc, instr} entries with
//               push, pop, flush and an occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_fetch_fifo
   import sr_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  fetch_entry_t           i_data,
   input  logic                   i_pop,
   input  logic                   i_flush,
   output fetch_entry_t           o_head,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int              c_AW   = $clog2(DEPTH);
   localparam logic [c_AW:0]   c_FULL = DEPTH[c_AW:0];

   fetch_entry_t    r_mem [DEPTH];
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_AW:0]   r_count;

   logic w_push;
   logic w_pop;
   logic w_full;

   assign o_empty = (r_count == '0);
   assign w_full  = (r_count == c_FULL);
   // A flush wins over everything; a push into a full FIFO is only legal
   // when the head leaves in the same cycle.
   assign w_pop   = i_pop & ~o_empty & ~i_flush;
   assign w_push  = i_push & ~i_flush & (~w_full | w_pop);

   // Entry storage; contents need no reset because r_count gates visibility
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy bookkeeping (pointers wrap since DEPTH is 2^n)
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         r_count <= r_count + {{c_AW{1'b0}}, w_push} - {{c_AW{1'b0}}, w_pop};
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/sr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : sr_fetch
// Description : Instruction fetch stage. Owns the PC, issues in-order requests
//               over a req/gnt/rvalid memory port, buffers returned words in a
//               prefetch FIFO and presents one instruction (or a NOP bubble)
//               per cycle to decode. Redirects flush and drop in-flight words.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_fetch
   import sr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = c_RESET_PC_DEFAULT,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        stall_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pcPlus4_o,
   output logic        bubble_o
);

   // Counter width holds 0..DEPTH; the sum width holds outstanding+occupancy
   localparam int              c_CW     = $clog2(DEPTH) + 1;
   localparam int              c_SW     = c_CW + 1;
   localparam logic [c_SW-1:0] c_DEPTH  = c_SW'(DEPTH);

   logic [31:0]     r_fetch_pc;
   logic [31:0]     r_shadow_pc;
   logic [c_CW-1:0] r_outstanding;
   logic [c_CW-1:0] r_discard;

   fetch_entry_t    w_head;
   fetch_entry_t    w_push_data;
   logic            w_empty;
   logic [c_CW-1:0] w_count;
   logic [c_SW-1:0] w_inflight;
   logic [31:0]     w_target;
   logic            w_issue;
   logic            w_resp;
   logic            w_push;
   logic            w_pop;

   assign w_target    = word_align(redirect_pc_i);
   assign bubble_o    = w_empty | redirect_i;
   assign w_pop       = ~bubble_o & ~stall_i;
   // A stray rvalid with nothing outstanding is not a response at all
   assign w_resp      = imem_rvalid_i & (r_outstanding != '0);
   assign w_push      = w_resp & (r_discard == '0) & ~redirect_i;
   assign w_push_data = '{pc: r_shadow_pc, instr: imem_rdata_i};

   // Slots already claimed by buffered or in-flight words. The head leaving
   // this edge frees its slot, which keeps zero-wait fetch at one per cycle;
   // the new response cannot land before the next edge.
   assign w_inflight  = {1'b0, r_outstanding} + {1'b0, w_count} - c_SW'(w_pop);
   assign imem_req_o  = ~rst & ~redirect_i & (w_inflight < c_DEPTH);
   assign imem_addr_o = r_fetch_pc;
   assign w_issue     = imem_req_o & imem_gnt_i;

   sr_fetch_fifo #(
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .i_flush (redirect_i),
      .o_head  (w_head),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // PC, shadow PC and request/discard accounting
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc    <= word_align(RESET_PC);
         r_shadow_pc   <= word_align(RESET_PC);
         r_outstanding <= '0;
         r_discard     <= '0;
      end else begin
         r_outstanding <= r_outstanding + c_CW'(w_issue) - c_CW'(w_resp);
         if (redirect_i) begin
            // Everything still in flight belongs to the old path
            r_fetch_pc  <= w_target;
            r_shadow_pc <= w_target;
            r_discard   <= r_outstanding - c_CW'(w_resp);
         end else begin
            if (w_issue) begin
               r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
               r_shadow_pc <= r_shadow_pc + 32'd4;
            end
            if (w_resp && (r_discard != '0)) begin
               r_discard <= r_discard - c_CW'(1);
            end
         end
      end
   end

   // Decode-facing outputs: FIFO head, or NOP with zeroed PCs on a bubble
   always_comb begin
      instr_o   = c_RV_NOP;
      pc_o      = 32'h0;
      pcPlus4_o = 32'h0;
      if (!bubble_o) begin
         instr_o   = w_head.instr;
         pc_o      = w_head.pc;
         pcPlus4_o = w_head.pc + 32'd4;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_fetch
// Description : Self-checking bench for sr_fetch: directed cycle table,
//               multi-cycle corner sequences and randomized traffic against a
//               program-order reference model with an in-order memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_fetch;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst, imem_req_o, imem_gnt_i, imem_rvalid_i;
   logic        redirect_i, stall_i, bubble_o;
   logic [31:0] imem_addr_o, imem_rdata_i, redirect_pc_i;
   logic [31:0] instr_o, pc_o, pcPlus4_o;

   always #5 clk = ~clk;

   sr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .stall_i       (stall_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .pcPlus4_o     (pcPlus4_o),
      .bubble_o      (bubble_o)
   );

   // Memory transaction: live = the fetch unit still counts it,
   // valid = it belongs to the current program path
   typedef struct { int unsigned due; logic [31:0] addr; bit live; bit valid; } mreq_t;
   mreq_t resp_q[$];

   typedef struct {
      bit g; bit s; bit rd; logic [31:0] rpc;
      bit ebub; logic [31:0] epc; bit ereq; logic [31:0] eaddr;
   } vec_t;
   vec_t tbl[18];

   int          total = 0;
   int          bad   = 0;
   int unsigned cyc   = 0;
   int unsigned lat_min = 1, lat_max = 1;
   bit          keep_on_reset = 1'b0;

   // Reference model: next PC decode must see, next PC memory must be asked
   // for, and words accepted on the current path but not yet consumed
   logic [31:0] exp_pc, exp_fetch;
   int          valid_words = 0;
   bit          prev_flush = 1'b0, prev_pend = 1'b0;
   logic [31:0] prev_addr = '0;

   bit          s_bubble, s_req;
   logic [31:0] s_addr, s_pc, s_instr, s_pcp4;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0050_0093;
         32'h4:   return 32'h0010_0113;
         32'h8:   return 32'h0020_81B3;
         32'hC:   return 32'h0000_0013;
         default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   function automatic int live_cnt();
      int n = 0;
      foreach (resp_q[i]) if (resp_q[i].live) n++;
      return n;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input bit r, input bit g, input bit s, input bit rd,
                        input logic [31:0] rpc, input bit rv_en);
      rst = r; imem_gnt_i = g; stall_i = s; redirect_i = rd; redirect_pc_i = rpc;
      if (rv_en && resp_q.size() > 0 && resp_q[0].due <= cyc) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = mem_word(resp_q[0].addr);
      end else begin
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = $urandom;
      end
   endtask

   // One clock: sample and check at negedge, advance model, pass posedge
   task automatic tick();
      mreq_t       h;
      int unsigned d;
      @(negedge clk);
      s_bubble = bubble_o; s_req = imem_req_o; s_addr = imem_addr_o;
      s_pc = pc_o; s_instr = instr_o; s_pcp4 = pcPlus4_o;
      if (rst) begin
         chk("req_in_reset", 32'(imem_req_o), 32'h0);
         exp_pc = RESET_PC; exp_fetch = RESET_PC; valid_words = 0;
         if (keep_on_reset) begin
            foreach (resp_q[i]) begin resp_q[i].live = 1'b0; resp_q[i].valid = 1'b0; end
         end else begin
            resp_q.delete();
         end
         prev_flush = 1'b1; prev_pend = 1'b0;
      end else begin
         if (redirect_i) begin
            chk("req_in_redirect", 32'(imem_req_o), 32'h0);
            chk("bubble_in_redirect", 32'(bubble_o), 32'h1);
         end
         if (prev_flush) chk("bubble_after_flush", 32'(bubble_o), 32'h1);
         if (bubble_o) begin
            chk("bubble_instr", instr_o, 32'h13);
            chk("bubble_pc", pc_o, 32'h0);
            chk("bubble_pc4", pcPlus4_o, 32'h0);
         end else begin
            chk("head_pc", pc_o, exp_pc);
            chk("head_instr", instr_o, mem_word(exp_pc));
            chk("head_pc4", pcPlus4_o, exp_pc + 32'd4);
         end
         if (!redirect_i && valid_words > 0) chk("word_visible", 32'(bubble_o), 32'h0);
         if (imem_req_o) chk("fetch_addr", imem_addr_o, exp_fetch);
         if (prev_pend && !redirect_i) begin
            chk("req_held", 32'(imem_req_o), 32'h1);
            chk("addr_held", imem_addr_o, prev_addr);
         end
         chk("capacity", 32'((live_cnt() + valid_words) <= DEPTH), 32'h1);

         if (imem_rvalid_i) begin
            h = resp_q.pop_front();
            if (h.live && h.valid && !redirect_i) valid_words++;
         end
         if (redirect_i) begin
            valid_words = 0;
            foreach (resp_q[i]) resp_q[i].valid = 1'b0;
            exp_pc    = redirect_pc_i & ~32'h3;
            exp_fetch = redirect_pc_i & ~32'h3;
         end else begin
            if (!bubble_o && !stall_i) begin
               if (valid_words > 0) valid_words--;
               exp_pc = exp_pc + 32'd4;
            end
            if (imem_req_o && imem_gnt_i) begin
               d = cyc + $urandom_range(lat_min, lat_max);
               if (resp_q.size() > 0 && resp_q[$].due >= d) d = resp_q[$].due + 1;
               resp_q.push_back('{due: d, addr: imem_addr_o, live: 1'b1, valid: 1'b1});
               exp_fetch = exp_fetch + 32'd4;
            end
         end
         prev_flush = redirect_i;
         prev_pend  = imem_req_o & ~imem_gnt_i & ~redirect_i;
         prev_addr  = imem_addr_o;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      tick();
   endtask

   initial begin
      bit          found;
      int          nb;
      bit          r, rd;
      logic [31:0] t;

      // Cycle table after reset release, zero-wait memory:
      // {gnt, stall, redirect, redirect_pc, exp_bubble, exp_pc, exp_req, exp_addr}
      tbl[0]  = '{1, 0, 0, 32'h0,   1, 32'h0,   1, 32'h0};
      tbl[1]  = '{1, 0, 0, 32'h0,   1, 32'h0,   1, 32'h4};
      tbl[2]  = '{0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h8};
      tbl[3]  = '{0, 0, 0, 32'h0,   0, 32'h4,   1, 32'h8};
      tbl[4]  = '{0, 0, 0, 32'h0,   1, 32'h0,   1, 32'h8};
      tbl[5]  = '{1, 0, 0, 32'h0,   1, 32'h0,   1, 32'h8};
      tbl[6]  = '{1, 0, 0, 32'h0,   1, 32'h0,   1, 32'hC};
      tbl[7]  = '{1, 0, 0, 32'h0,   0, 32'h8,   1, 32'h10};
      tbl[8]  = '{1, 1, 0, 32'h0,   0, 32'hC,   0, 32'h14};
      tbl[9]  = '{1, 1, 0, 32'h0,   0, 32'hC,   0, 32'h14};
      tbl[10] = '{1, 1, 0, 32'h0,   0, 32'hC,   0, 32'h14};
      tbl[11] = '{1, 1, 0, 32'h0,   0, 32'hC,   0, 32'h14};
      tbl[12] = '{1, 0, 0, 32'h0,   0, 32'hC,   1, 32'h14};
      tbl[13] = '{1, 0, 0, 32'h0,   0, 32'h10,  1, 32'h18};
      tbl[14] = '{1, 0, 1, 32'h103, 1, 32'h0,   0, 32'h1C};
      tbl[15] = '{1, 0, 0, 32'h0,   1, 32'h0,   1, 32'h100};
      tbl[16] = '{1, 0, 0, 32'h0,   1, 32'h0,   1, 32'h104};
      tbl[17] = '{1, 0, 0, 32'h0,   0, 32'h100, 1, 32'h108};

      exp_pc = RESET_PC; exp_fetch = RESET_PC;
      lat_min = 1; lat_max = 1;
      do_reset();
      for (int i = 0; i < 18; i++) begin
         drive(1'b0, tbl[i].g, tbl[i].s, tbl[i].rd, tbl[i].rpc, 1'b1);
         tick();
         chk($sformatf("tbl%0d_bubble", i), 32'(s_bubble), 32'(tbl[i].ebub));
         chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].ereq));
         chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].eaddr);
         chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].ebub ? 32'h0 : tbl[i].epc);
         chk($sformatf("tbl%0d_instr", i), s_instr, tbl[i].ebub ? 32'h13 : mem_word(tbl[i].epc));
         chk($sformatf("tbl%0d_pc4", i), s_pcp4, tbl[i].ebub ? 32'h0 : tbl[i].epc + 32'd4);
      end

      // Redirect with two requests in flight: both words dropped, 0x100 next
      do_reset();
      lat_min = 3; lat_max = 3;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1); tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1); tick();
      chk("seqA_two_inflight", 32'(live_cnt()), 32'h2);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1); tick();
      chk("seqA_redir_bubble", 32'(s_bubble), 32'h1);
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1); tick();
         if (!s_bubble) begin
            found = 1'b1;
            chk("seqA_first_pc", s_pc, 32'h100);
         end
      end
      chk("seqA_found", 32'(found), 32'h1);

      // Zero-wait throughput: after the 2-cycle startup, no bubbles
      do_reset();
      lat_min = 1; lat_max = 1;
      nb = 0;
      for (int i = 0; i < 40; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1); tick();
         if (i >= 2 && s_bubble) nb++;
      end
      chk("throughput_bubbles", 32'(nb), 32'h0);

      // Reset with two outstanding; late responses afterwards are ignored
      do_reset();
      lat_min = 3; lat_max = 3;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1); tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1); tick();
      keep_on_reset = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1); tick();
      chk("seqB_req", 32'(s_req), 32'h1);
      chk("seqB_addr", s_addr, RESET_PC);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1); tick();
         chk("seqB_stray_ignored", 32'(s_bubble), 32'h1);
      end
      chk("seqB_strays_drained", 32'(resp_q.size()), 32'h0);
      keep_on_reset = 1'b0;

      // PC wrap-around past the top of the address space
      lat_min = 1; lat_max = 1;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1); tick();
      found = 1'b0;
      for (int i = 0; i < 15 && !found; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1); tick();
         if (!s_bubble && s_pc == 32'hFFFF_FFFC) begin
            found = 1'b1;
            chk("wrap_pc4", s_pcp4, 32'h0);
         end
      end
      chk("wrap_found", 32'(found), 32'h1);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1); tick();
      end

      // Randomized traffic: grant gaps, variable latency, stalls, redirects
      lat_min = 1; lat_max = 3;
      for (int n = 0; n < 3000; n++) begin
         r  = ($urandom_range(0, 199) == 0);
         rd = !r && ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         else                           t = $urandom;
         drive(r, $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, rd, t, 1'b1);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
